// File: rtl/next_hotkey_decoder.sv
// next_hotkey_decoder
//
// Watches the keyboard event stream. It recognises a held modifier chord
// followed by a key press and turns it into hotkey commands with
// auto-repeat. While the chord is held, normal keys are kept away from the
// NeXT host.
//
// Keycode format: [6:0] key code (0 = no key), [7] release flag,
// [14:8] modifier bitmap, [15] normal-key flag.
//
// Ports:
//   clk27          in   FPGA clock, the only clock of the block
//   reset          in   asynchronous, active-high reset
//   keycode_in     in   16-bit keyboard event
//   keycode_valid  in   one-cycle strobe qualifying keycode_in
//   cmd_code       out  key code of the hotkey command (held between strobes)
//   cmd_valid      out  one-cycle command strobe
//   cmd_repeat     out  0 = initial press, 1 = auto-repeat (valid with cmd_valid)
//   hotkey_active  out  high whenever the FSM is not IDLE
//   kb_forward_en  out  drives enable_next_keyboard; high only in IDLE
//   state_dbg      out  raw FSM state for debug/observation
//
// Handshake: keycode_valid is a plain strobe with no back-pressure; every
// strobe is consumed in the cycle it is asserted, including back-to-back
// strobes. cmd_valid is likewise a one-cycle strobe with no ready.

module next_hotkey_decoder #(
    parameter logic [6:0] HOTKEY_MODS   = 7'b0011000,
    parameter int         REPEAT_DELAY  = 13500000,
    parameter int         REPEAT_PERIOD = 2700000,
    parameter int         CNT_W         = 24
) (
    input  logic        clk27,
    input  logic        reset,
    input  logic [15:0] keycode_in,
    input  logic        keycode_valid,
    output logic [6:0]  cmd_code,
    output logic        cmd_valid,
    output logic        cmd_repeat,
    output logic        hotkey_active,
    output logic        kb_forward_en,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // The counter is loaded with the full delay/period rather than one less:
    // the repeat is detected in the cnt==0 cycle and then spends one more
    // cycle in the output register, which yields a first repeat
    // REPEAT_DELAY+1 cycles after the initial strobe and REPEAT_PERIOD+1
    // cycles between later repeats.
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [6:0]       held_key_q, held_key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [6:0]       cmd_code_q, cmd_code_d;
    logic             cmd_repeat_q, cmd_repeat_d;

    // Event decode
    logic       match;
    logic       key_down;
    logic       key_up;
    logic [6:0] ev_key;

    assign ev_key   = keycode_in[6:0];
    assign match    = ((keycode_in[14:8] & HOTKEY_MODS) == HOTKEY_MODS);
    assign key_down = keycode_in[15] && !keycode_in[7] && (ev_key != 7'd0);
    assign key_up   = keycode_in[15] && keycode_in[7];

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            held_key_q   <= 7'd0;
            cnt_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 7'd0;
            cmd_repeat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_key_q   <= held_key_d;
            cnt_q        <= cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_repeat_q <= cmd_repeat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        held_key_d   = held_key_q;
        cnt_d        = cnt_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        cmd_repeat_d = cmd_repeat_q;

        unique case (state_q)
            ST_IDLE: begin
                // The arming event is never turned into a command.
                if (keycode_valid && match) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (keycode_valid) begin
                    if (!match) begin
                        state_d = ST_IDLE;
                    end else if (key_down) begin
                        cmd_valid_d  = 1'b1;
                        cmd_code_d   = ev_key;
                        cmd_repeat_d = 1'b0;
                        held_key_d   = ev_key;
                        cnt_d        = DELAY_LOAD;
                        state_d      = ST_HELD;
                    end
                end
            end

            ST_HELD: begin
                if (keycode_valid) begin
                    // Events take priority over a due repeat; cnt is frozen
                    // unless a new key restarts it.
                    if (!match) begin
                        state_d = ST_IDLE;
                    end else if (key_up && (ev_key == held_key_q)) begin
                        state_d = ST_ARMED;
                    end else if (key_down && (ev_key != held_key_q)) begin
                        cmd_valid_d  = 1'b1;
                        cmd_code_d   = ev_key;
                        cmd_repeat_d = 1'b0;
                        held_key_d   = ev_key;
                        cnt_d        = DELAY_LOAD;
                    end
                end else if (cnt_q == '0) begin
                    cmd_valid_d  = 1'b1;
                    cmd_code_d   = held_key_q;
                    cmd_repeat_d = 1'b1;
                    cnt_d        = PERIOD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_valid     = cmd_valid_q;
    assign cmd_code      = cmd_code_q;
    assign cmd_repeat    = cmd_repeat_q;
    assign hotkey_active = (state_q != ST_IDLE);
    assign kb_forward_en = (state_q == ST_IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_next_hotkey_decoder.sv
// Testbench for next_hotkey_decoder, run with REPEAT_DELAY=20 and
// REPEAT_PERIOD=5. A behavioural model counts event-free cycles spent
// holding a key and predicts every command; predicted commands go into an
// expected queue that is drained against the DUT's cmd_valid strobes.

module tb_next_hotkey_decoder;

    localparam int         DELAY  = 20;
    localparam int         PERIOD = 5;
    localparam logic [6:0] MODS   = 7'b0011000;

    logic        clk27 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keycode_in = 16'h0000;
    logic        keycode_valid = 1'b0;
    logic [6:0]  cmd_code;
    logic        cmd_valid;
    logic        cmd_repeat;
    logic        hotkey_active;
    logic        kb_forward_en;
    logic [1:0]  state_dbg;

    next_hotkey_decoder #(
        .HOTKEY_MODS   (MODS),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_PERIOD (PERIOD),
        .CNT_W         (8)
    ) dut (
        .clk27         (clk27),
        .reset         (reset),
        .keycode_in    (keycode_in),
        .keycode_valid (keycode_valid),
        .cmd_code      (cmd_code),
        .cmd_valid     (cmd_valid),
        .cmd_repeat    (cmd_repeat),
        .hotkey_active (hotkey_active),
        .kb_forward_en (kb_forward_en),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk27 = ~clk27;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];   // {repeat, code} of each predicted command

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_hold: 0 = chord not held, 1 = chord held without key, 2 = chord + key held.
    // m_free counts event-free cycles since the last (re)start of the repeat
    // timer; a repeat is due when it reaches m_need.
    int         m_hold = 0;
    logic [6:0] m_key = 7'd0;
    int         m_free = 0;
    int         m_need = 0;
    logic [6:0] exp_code = 7'd0;
    logic       exp_rep = 1'b0;
    logic       exp_act = 1'b0;

    task automatic model_reset();
        m_hold = 0;
        m_key = 7'd0;
        m_free = 0;
        m_need = 0;
        exp_code = 7'd0;
        exp_rep = 1'b0;
        exp_act = 1'b0;
        exp_q.delete();
    endtask

    task automatic emit(input logic rep, input logic [6:0] code);
        exp_q.push_back({rep, code});
        exp_code = code;
        exp_rep = rep;
    endtask

    task automatic model_step(input logic v, input logic [15:0] k);
        bit match, kd, ku;
        match = ((k[14:8] & MODS) == MODS);
        kd = k[15] && !k[7] && (k[6:0] != 7'd0);
        ku = k[15] && k[7];
        if (m_hold == 0) begin
            if (v && match) m_hold = 1;
        end else if (m_hold == 1) begin
            if (v && !match) m_hold = 0;
            else if (v && kd) begin
                emit(1'b0, k[6:0]);
                m_key = k[6:0];
                m_free = 0;
                m_need = DELAY + 1;
                m_hold = 2;
            end
        end else begin
            if (v) begin
                if (!match) m_hold = 0;
                else if (ku && k[6:0] == m_key) m_hold = 1;
                else if (kd && k[6:0] != m_key) begin
                    emit(1'b0, k[6:0]);
                    m_key = k[6:0];
                    m_free = 0;
                    m_need = DELAY + 1;
                end
            end else begin
                m_free++;
                if (m_free == m_need) begin
                    emit(1'b1, m_key);
                    m_free = 0;
                    m_need = PERIOD + 1;
                end
            end
        end
        exp_act = (m_hold != 0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: checks the outputs settled after the last
    // posedge, then drives the next cycle's inputs and advances the model.
    task automatic check_outputs();
        logic [7:0] e;
        check("cmd_valid", cmd_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cmd_repeat@strobe", cmd_repeat, e[7]);
            check("cmd_code@strobe", cmd_code, e[6:0]);
        end
        check("cmd_code", cmd_code, exp_code);
        check("cmd_repeat", cmd_repeat, exp_rep);
        check("hotkey_active", hotkey_active, exp_act);
        check("kb_forward_en", kb_forward_en, !exp_act);
    endtask

    task automatic step(input logic v, input logic [15:0] k);
        check_outputs();
        keycode_valid = v;
        keycode_in = k;
        model_step(v, k);
        @(negedge clk27);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    task automatic reset_mid_cycle();
        keycode_valid = 1'b0;
        keycode_in = 16'h0000;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_code", cmd_code, 7'd0);
        check("rst_cmd_repeat", cmd_repeat, 1'b0);
        check("rst_hotkey_active", hotkey_active, 1'b0);
        check("rst_kb_forward_en", kb_forward_en, 1'b1);
        @(negedge clk27);
        @(negedge clk27);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_event();
        logic [6:0] mods;
        logic [6:0] key;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) mods = MODS;
        else if (sel == 6) mods = 7'h00;
        else if (sel == 7) mods = 7'b0011100;
        else if (sel == 8) mods = 7'b0001000;
        else mods = 7'($urandom_range(0, 127));
        key = 7'($urandom_range(0, 3));
        return {1'($urandom_range(0, 3) != 0), mods, 1'($urandom_range(0, 2) == 0), key};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk27);
        @(negedge clk27);
        reset = 1'b0;

        // Chord, key 3 down, key 3 up: one initial command, back to ARMED.
        step(1'b1, 16'h1800);
        step(1'b1, 16'h9803);
        idle(3);
        step(1'b1, 16'h9883);
        idle(30);

        // Still armed: press key 0x10 and hold for 40 cycles (repeats at +21, +27, ...).
        step(1'b1, 16'h9810);
        idle(40);

        // Modifiers released while holding: back to IDLE, repeats stop.
        step(1'b1, 16'h0000);
        idle(30);

        // Chord and key in the same event from IDLE: arms only.
        step(1'b1, 16'h9810);
        idle(3);

        // Key down from ARMED, then an event exactly on the cnt==0 cycle.
        step(1'b1, 16'h9810);
        idle(DELAY);
        step(1'b1, 16'h1800);
        idle(10);

        // Back-to-back strobes: new key, same key, foreign key-up, held key-up.
        step(1'b1, 16'h9805);
        step(1'b1, 16'h9805);
        step(1'b1, 16'h9881);
        step(1'b1, 16'h9885);
        idle(5);

        // Asynchronous reset while holding a key.
        step(1'b1, 16'h1800);
        step(1'b1, 16'h9802);
        idle(8);
        reset_mid_cycle();
        idle(40);

        // Randomised traffic with long quiet stretches so repeats fire.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) step(1'b1, rand_event());
            else step(1'b0, 16'($urandom));
        end
        idle(30);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
